// File: rtl/apb_dtcp_if_mc.sv
// Multi-channel APB slave in front of NUM_CH FthDataCp copy engines and the shared InBuf/OutBuf memories.
// Define APB_DTCP_SLVERR_EN to report illegal accesses on oPslverr; otherwise they complete silently.
module apb_dtcp_if_mc #(
  parameter int NUM_CH = 2,
  parameter int BUF_AW = 9,
  parameter int RD_LAT = 1
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic                         iPsel,
  input  logic                         iPenable,
  input  logic                         iPwrite,
  input  logic [15:0]                  iPaddr,
  input  logic [31:0]                  iPwdata,
  output logic [31:0]                  oPrdata,
  output logic                         oPready,
  output logic                         oPslverr,
  output logic [NUM_CH-1:0]            oStDtCp,
  output logic [NUM_CH*(BUF_AW+1)-1:0] oPktWdSize,
  input  logic [NUM_CH-1:0]            iDtCpDone,
  output logic                         oWrEn_InBuf,
  output logic [BUF_AW-1:0]            oWrAddr_InBuf,
  output logic [31:0]                  oWrDt_InBuf,
  output logic                         oRdEn_OutBuf,
  output logic [BUF_AW-1:0]            oRdAddr_OutBuf,
  input  logic [31:0]                  iRdDt_OutBuf,
  output logic                         oIrq
);

  localparam logic [31:0] MAX_SIZE = 32'd1 << BUF_AW;

  typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} stateT;

  stateT             state;
  logic [1:0]        waitCnt;
  logic [31:0]       rPrdata;
  logic [BUF_AW:0]   size [NUM_CH];
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] irqEn;

  logic [NUM_CH-1:0] chHit;
  logic              offCtrl, offSize, offStat;
  logic              regHit, irqHit, inBufHit, outBufHit;
  logic              illegal, access, wrCommit, rdLaunch, irqWr, inWr;
  logic [31:0]       regRdData;
  logic [NUM_CH-1:0] startFire, sizeWr, statW1c;

  assign offCtrl   = (iPaddr[3:0] == 4'h0);
  assign offSize   = (iPaddr[3:0] == 4'h4);
  assign offStat   = (iPaddr[3:0] == 4'h8);
  assign regHit    = (|chHit) && (offCtrl || offSize || offStat);
  assign irqHit    = (iPaddr == 16'h0100);
  assign inBufHit  = (iPaddr[15:13] == 3'b010);
  assign outBufHit = (iPaddr[15:13] == 3'b011);

  // Decode is evaluated on the live APB address both at setup (read data) and in the access cycle (legality).
  always_comb begin
    chHit     = '0;
    illegal   = 1'b0;
    regRdData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      chHit[c] = (iPaddr[15:8] == 8'h00) && (iPaddr[7:4] == 4'(c));
      if (chHit[c]) begin
        if (offSize) regRdData = 32'(size[c]);
        if (offStat) regRdData = {30'd0, done[c], busy[c]};
        if (iPwrite && offCtrl && iPwdata[0] && (busy[c] || size[c] == '0)) illegal = 1'b1;
        if (iPwrite && offSize && (busy[c] || iPwdata > MAX_SIZE)) illegal = 1'b1;
      end
    end
    if (irqHit) regRdData = 32'(irqEn);
    if (!(regHit || irqHit || inBufHit || outBufHit)) illegal = 1'b1;
    if (iPwrite && outBufHit) illegal = 1'b1;
    if (!iPwrite && inBufHit) illegal = 1'b1;
  end

  assign access   = (state == RESP) && iPsel && iPenable;
  assign wrCommit = access && iPwrite && !illegal;
  assign rdLaunch = (state == IDLE) && iPsel && !iPenable && !iPwrite && outBufHit;
  assign irqWr    = wrCommit && irqHit;
  assign inWr     = wrCommit && inBufHit;

  always_comb begin
    startFire = '0;
    sizeWr    = '0;
    statW1c   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      startFire[c] = wrCommit && chHit[c] && offCtrl && iPwdata[0];
      sizeWr[c]    = wrCommit && chHit[c] && offSize;
      statW1c[c]   = wrCommit && chHit[c] && offStat && iPwdata[1];
    end
  end

  // Single sequencer: APB handshake FSM plus the per-channel register file it commits into.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      waitCnt <= '0;
      rPrdata <= '0;
      busy    <= '0;
      done    <= '0;
      irqEn   <= '0;
      for (int c = 0; c < NUM_CH; c++) size[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iPsel && !iPenable) begin
            if (rdLaunch) begin
              waitCnt <= 2'(RD_LAT);
              state   <= MEM_WAIT;
            end else begin
              if (!iPwrite) rPrdata <= regRdData;
              state <= RESP;
            end
          end
        end
        MEM_WAIT: begin
          if (!iPsel) begin
            state <= IDLE;
          end else if (waitCnt == 2'd1) begin
            rPrdata <= iRdDt_OutBuf;
            state   <= RESP;
          end else begin
            waitCnt <= waitCnt - 2'd1;
          end
        end
        RESP: begin
          if (!iPsel || iPenable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A completion landing together with a DONE clear must leave DONE set.
      for (int c = 0; c < NUM_CH; c++) begin
        if (startFire[c]) begin
          busy[c] <= 1'b1;
          done[c] <= 1'b0;
        end else if (busy[c] && iDtCpDone[c]) begin
          busy[c] <= 1'b0;
          done[c] <= 1'b1;
        end else if (statW1c[c]) begin
          done[c] <= 1'b0;
        end
        if (sizeWr[c]) size[c] <= iPwdata[BUF_AW:0];
      end
      if (irqWr) irqEn <= iPwdata[NUM_CH-1:0];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : gPack
      assign oPktWdSize[g*(BUF_AW+1) +: BUF_AW+1] = size[g];
    end
  endgenerate

  assign oPrdata        = rPrdata;
  assign oPready        = access;
  assign oStDtCp        = startFire;
  assign oWrEn_InBuf    = inWr;
  assign oWrAddr_InBuf  = inWr ? iPaddr[BUF_AW+1:2] : '0;
  assign oWrDt_InBuf    = inWr ? iPwdata : '0;
  assign oRdEn_OutBuf   = rdLaunch;
  assign oRdAddr_OutBuf = rdLaunch ? iPaddr[BUF_AW+1:2] : '0;
  assign oIrq           = |(done & irqEn);

`ifdef APB_DTCP_SLVERR_EN
  assign oPslverr = access && illegal;
`else
  assign oPslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_dtcp_if_mc.sv
// Scoreboarded bench for apb_dtcp_if_mc: APB tasks queue expected responses, a monitor checks each completed transfer.
module tb_apb_dtcp_if_mc;

  localparam int NUM_CH = 2;
  localparam int BUF_AW = 9;
  localparam int RD_LAT = 2;
`ifdef APB_DTCP_SLVERR_EN
  localparam logic SLVERR_ON = 1'b1;
`else
  localparam logic SLVERR_ON = 1'b0;
`endif

  logic                         iClk, iRst, iPsel, iPenable, iPwrite;
  logic [15:0]                  iPaddr;
  logic [31:0]                  iPwdata, oPrdata, oWrDt_InBuf, iRdDt_OutBuf;
  logic                         oPready, oPslverr, oWrEn_InBuf, oRdEn_OutBuf, oIrq;
  logic [NUM_CH-1:0]            oStDtCp, iDtCpDone;
  logic [NUM_CH*(BUF_AW+1)-1:0] oPktWdSize;
  logic [BUF_AW-1:0]            oWrAddr_InBuf, oRdAddr_OutBuf;

  apb_dtcp_if_mc #(.NUM_CH(NUM_CH), .BUF_AW(BUF_AW), .RD_LAT(RD_LAT)) dut (
    .iClk(iClk), .iRst(iRst), .iPsel(iPsel), .iPenable(iPenable), .iPwrite(iPwrite),
    .iPaddr(iPaddr), .iPwdata(iPwdata), .oPrdata(oPrdata), .oPready(oPready),
    .oPslverr(oPslverr), .oStDtCp(oStDtCp), .oPktWdSize(oPktWdSize), .iDtCpDone(iDtCpDone),
    .oWrEn_InBuf(oWrEn_InBuf), .oWrAddr_InBuf(oWrAddr_InBuf), .oWrDt_InBuf(oWrDt_InBuf),
    .oRdEn_OutBuf(oRdEn_OutBuf), .oRdAddr_OutBuf(oRdAddr_OutBuf), .iRdDt_OutBuf(iRdDt_OutBuf),
    .oIrq(oIrq)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic        isRead;
    logic [31:0] data;
    logic        err;
    int          waits;
  } expT;

  expT   expQ[$];
  string nameQ[$];
  int    testsRun = 0;
  int    testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // OutBuf model with RD_LAT pipeline stages between read enable and data.
  logic [31:0] outMem [0:511];
  logic [31:0] rdPipe [RD_LAT];
  always @(posedge iClk) begin
    rdPipe[0] <= oRdEn_OutBuf ? outMem[oRdAddr_OutBuf] : 32'h0;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign iRdDt_OutBuf = rdPipe[RD_LAT-1];

  // Scoreboard monitor.
  expT   monExp;
  string monName;
  int    monWaits = 0;
  always @(negedge iClk) begin
    if (!iRst && iPsel && iPenable) begin
      if (!oPready) begin
        monWaits++;
      end else begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected completion: addr 0x%0h", iPaddr);
        end else begin
          monExp  = expQ.pop_front();
          monName = nameQ.pop_front();
          if (monExp.isRead) checkOutput({monName, " prdata"}, 64'(oPrdata), 64'(monExp.data));
          checkOutput({monName, " pslverr"}, 64'(oPslverr), 64'(monExp.err));
          checkOutput({monName, " waits"}, 64'(monWaits), 64'(monExp.waits));
        end
        monWaits = 0;
      end
    end
  end

  int wrEnCount = 0, stCount = 0, rdEnCount = 0;
  logic [BUF_AW-1:0] lastWrAddr, lastRdAddr;
  logic [31:0]       lastWrDt;
  logic [NUM_CH-1:0] lastSt;
  always @(negedge iClk) begin
    if (oWrEn_InBuf) begin
      wrEnCount++;
      lastWrAddr = oWrAddr_InBuf;
      lastWrDt   = oWrDt_InBuf;
    end
    if (oStDtCp != '0) begin
      stCount++;
      lastSt = oStDtCp;
    end
    if (oRdEn_OutBuf) begin
      rdEnCount++;
      lastRdAddr = oRdAddr_OutBuf;
    end
  end

  task automatic applyStimulus(input string name, input logic wr, input logic [15:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input logic expErr, input int expWaits, input logic [NUM_CH-1:0] doneAtAccess);
    expT e;
    int  n;
    e.isRead = !wr;
    e.data   = expData;
    e.err    = expErr & SLVERR_ON;
    e.waits  = expWaits;
    expQ.push_back(e);
    nameQ.push_back(name);
    @(posedge iClk); #1;
    iPsel = 1'b1; iPenable = 1'b0; iPwrite = wr; iPaddr = addr; iPwdata = wdata;
    @(posedge iClk); #1;
    iPenable  = 1'b1;
    iDtCpDone = doneAtAccess;
    n = 0;
    @(negedge iClk);
    while (!oPready && n < 20) begin
      n++;
      @(negedge iClk);
    end
    if (!oPready) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL %s timeout: no PREADY after %0d cycles, expected %0d waits", name, n, expWaits);
      void'(expQ.pop_back());
      void'(nameQ.pop_back());
    end
    @(posedge iClk); #1;
    iPsel = 1'b0; iPenable = 1'b0; iDtCpDone = '0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 512; i++) outMem[i] = 32'hA5A50000 | i;
    outMem[3] = 32'h12345678;
    iRst = 1'b1; iPsel = 1'b0; iPenable = 1'b0; iPwrite = 1'b0;
    iPaddr = '0; iPwdata = '0; iDtCpDone = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk);
    checkOutput("reset prdata", 64'(oPrdata), 64'd0);
    checkOutput("reset pready", 64'(oPready), 64'd0);
    checkOutput("reset pslverr", 64'(oPslverr), 64'd0);
    checkOutput("reset stDtCp", 64'(oStDtCp), 64'd0);
    checkOutput("reset pktWdSize", 64'(oPktWdSize), 64'd0);
    checkOutput("reset wrEn", 64'({oWrEn_InBuf, oWrAddr_InBuf, oWrDt_InBuf}), 64'd0);
    checkOutput("reset rdEn", 64'({oRdEn_OutBuf, oRdAddr_OutBuf}), 64'd0);
    checkOutput("reset irq", 64'(oIrq), 64'd0);
    @(posedge iClk); #1;
    iRst = 1'b0;

    applyStimulus("rd stat0 after reset", 1'b0, 16'h0008, 0, 32'h0, 1'b0, 0, '0);
    applyStimulus("wr inbuf 0x4008", 1'b1, 16'h4008, 32'hDEADBEEF, 0, 1'b0, 0, '0);
    checkOutput("inbuf wrEn pulses", 64'(wrEnCount), 64'd1);
    checkOutput("inbuf wrAddr", 64'(lastWrAddr), 64'd2);
    checkOutput("inbuf wrDt", 64'(lastWrDt), 64'hDEADBEEF);

    applyStimulus("start ch1 size0", 1'b1, 16'h0010, 32'h1, 0, 1'b1, 0, '0);
    checkOutput("no pulse size0", 64'(stCount), 64'd0);
    applyStimulus("wr size1 0x200", 1'b1, 16'h0014, 32'h200, 0, 1'b0, 0, '0);
    checkOutput("pktWdSize ch1", 64'(oPktWdSize), 64'h80000);
    applyStimulus("start ch1", 1'b1, 16'h0010, 32'h1, 0, 1'b0, 0, '0);
    checkOutput("start pulses", 64'(stCount), 64'd1);
    checkOutput("start vector", 64'(lastSt), 64'h2);
    applyStimulus("rd stat1 busy", 1'b0, 16'h0018, 0, 32'h1, 1'b0, 0, '0);
    applyStimulus("start ch1 busy", 1'b1, 16'h0010, 32'h1, 0, 1'b1, 0, '0);
    checkOutput("no pulse busy", 64'(stCount), 64'd1);
    applyStimulus("wr size1 busy", 1'b1, 16'h0014, 32'h5, 0, 1'b1, 0, '0);
    applyStimulus("rd size1 kept", 1'b0, 16'h0014, 0, 32'h200, 1'b0, 0, '0);

    applyStimulus("wr irqEn", 1'b1, 16'h0100, 32'h2, 0, 1'b0, 0, '0);
    applyStimulus("rd irqEn", 1'b0, 16'h0100, 0, 32'h2, 1'b0, 0, '0);
    @(posedge iClk); #1; iDtCpDone = 2'b10;
    @(posedge iClk); #1; iDtCpDone = 2'b00;
    applyStimulus("rd stat1 done", 1'b0, 16'h0018, 0, 32'h2, 1'b0, 0, '0);
    checkOutput("irq after done", 64'(oIrq), 64'd1);
    applyStimulus("w1c done1", 1'b1, 16'h0018, 32'h2, 0, 1'b0, 0, '0);
    checkOutput("irq after w1c", 64'(oIrq), 64'd0);
    applyStimulus("rd stat1 cleared", 1'b0, 16'h0018, 0, 32'h0, 1'b0, 0, '0);

    applyStimulus("restart ch1", 1'b1, 16'h0010, 32'h1, 0, 1'b0, 0, '0);
    checkOutput("restart pulses", 64'(stCount), 64'd2);
    applyStimulus("w1c with done", 1'b1, 16'h0018, 32'h2, 0, 1'b0, 0, 2'b10);
    applyStimulus("rd stat1 set wins", 1'b0, 16'h0018, 0, 32'h2, 1'b0, 0, '0);
    checkOutput("irq set wins", 64'(oIrq), 64'd1);

    @(posedge iClk); #1; iDtCpDone = 2'b01;
    @(posedge iClk); #1; iDtCpDone = 2'b00;
    applyStimulus("rd stat0 idle done", 1'b0, 16'h0008, 0, 32'h0, 1'b0, 0, '0);

    applyStimulus("rd outbuf 0x600C", 1'b0, 16'h600C, 0, 32'h12345678, 1'b0, RD_LAT, '0);
    checkOutput("outbuf rdEn pulses", 64'(rdEnCount), 64'd1);
    checkOutput("outbuf rdAddr", 64'(lastRdAddr), 64'd3);

    applyStimulus("wr size0 oversize", 1'b1, 16'h0004, 32'h201, 0, 1'b1, 0, '0);
    applyStimulus("rd size0 unchanged", 1'b0, 16'h0004, 0, 32'h0, 1'b0, 0, '0);
    applyStimulus("wr size0 max", 1'b1, 16'h0004, 32'h200, 0, 1'b0, 0, '0);
    applyStimulus("rd size0 max", 1'b0, 16'h0004, 0, 32'h200, 1'b0, 0, '0);
    checkOutput("pktWdSize both", 64'(oPktWdSize), 64'h80200);
    applyStimulus("rd unmapped 0x200", 1'b0, 16'h0200, 0, 32'h0, 1'b1, 0, '0);
    applyStimulus("wr outbuf", 1'b1, 16'h6000, 32'h1, 0, 1'b1, 0, '0);
    checkOutput("no inbuf wr", 64'(wrEnCount), 64'd1);
    applyStimulus("rd inbuf", 1'b0, 16'h4000, 0, 32'h0, 1'b1, 0, '0);
    applyStimulus("rd offset 0xC", 1'b0, 16'h000C, 0, 32'h0, 1'b1, 0, '0);
    applyStimulus("rd ch2 absent", 1'b0, 16'h0028, 0, 32'h0, 1'b1, 0, '0);
    applyStimulus("rd ctrl0", 1'b0, 16'h0000, 0, 32'h0, 1'b0, 0, '0);

    @(posedge iClk); #1;
    iPsel = 1'b1; iPenable = 1'b0; iPwrite = 1'b1; iPaddr = 16'h0100; iPwdata = 32'h0;
    @(posedge iClk); #1;
    iPsel = 1'b0;
    @(posedge iClk); #1;
    applyStimulus("irqEn after psel drop", 1'b0, 16'h0100, 0, 32'h2, 1'b0, 0, '0);

    @(posedge iClk); #1;
    iPsel = 1'b1; iPenable = 1'b0; iPwrite = 1'b1; iPaddr = 16'h4010; iPwdata = 32'h55;
    @(posedge iClk); #1;
    iPenable = 1'b1;
    #1 iRst = 1'b1;
    @(negedge iClk);
    checkOutput("reset cancels wrEn", 64'(oWrEn_InBuf), 64'd0);
    checkOutput("reset pready", 64'(oPready), 64'd0);
    checkOutput("reset clears irq", 64'(oIrq), 64'd0);
    checkOutput("reset clears size", 64'(oPktWdSize), 64'd0);
    @(posedge iClk); #1;
    iPsel = 1'b0; iPenable = 1'b0;
    @(posedge iClk); #1;
    iRst = 1'b0;
    applyStimulus("rd stat1 after reset", 1'b0, 16'h0018, 0, 32'h0, 1'b0, 0, '0);
    checkOutput("inbuf wr count final", 64'(wrEnCount), 64'd1);

    repeat (2) @(posedge iClk);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
